regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DW, default 32, data width in bits.
REQ-002 The block SHALL have parameter AW, default 5, address width; depth DEPTH = 2**AW.
REQ-003 The block SHALL have parameter NR, default 2, number of read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and is never written or marked pending.
REQ-005 The block SHALL have ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  reset, asynchronous, active-high
Clr  in  1  synchronous request to start a clear sweep
Ready  out  1  1 = array usable; 0 = clear sweep in progress
RA  in  NR*AW  read addresses; port k uses bits [k*AW +: AW]
RD  out  NR*DW  read data; port k uses bits [k*DW +: DW]
RBusy  out  NR  per-port pending flag of the addressed register
We  in  1  write-back enable
WA  in  AW  write address
WD  in  DW  write data
Iss  in  1  issue: mark register IA pending
IA  in  AW  issue destination address

Function
REQ-006 The block SHALL implement a two-state FSM: CLEAR (Ready=0), IDLE (Ready=1).
REQ-007 In CLEAR, the block SHALL write 0 to entry cnt on each rising edge, then increment cnt (AW bits).
REQ-008 On the edge writing entry DEPTH-1, the FSM SHALL go to IDLE; Ready SHALL be 1 from that edge on, after exactly DEPTH edges of sweep.
REQ-009 Clr=1 on an edge in any state SHALL set cnt=0, clear all pending bits, and enter CLEAR; that edge writes no entry.
REQ-010 In CLEAR, We and Iss SHALL be ignored; RD and RBusy SHALL be all zeros.
REQ-011 In IDLE, We=1 SHALL write WD to entry WA on the rising edge, except when ZERO_REG=1 and WA=0.
REQ-012 Reads SHALL be combinational; in IDLE, port k SHALL return WD when We=1, WA=RA_k, and the write is not suppressed per REQ-011; otherwise it SHALL return the stored entry.
REQ-013 With ZERO_REG=1, any port addressing 0 SHALL return 0 and RBusy=0 regardless of We or pending state.
REQ-014 The block SHALL keep one pending bit per entry; in IDLE, We=1 SHALL clear pending[WA] and Iss=1 SHALL set pending[IA] on the edge.
REQ-015 Iss and We to the same address in one cycle SHALL leave the pending bit set (new producer wins).
REQ-016 Iss to an already-pending entry SHALL leave it set, with no error.
REQ-017 RBusy_k SHALL equal pending[RA_k] AND NOT (We AND WA=RA_k), so a same-cycle write-back clears busy combinationally, consistent with the REQ-012 bypass.
REQ-018 Iss in a cycle SHALL NOT affect RBusy in that same cycle; it takes effect from the next edge.
REQ-019 All read ports SHALL behave identically and independently; any combination of equal addresses SHALL be legal.

Reset
REQ-020 Rst=1 SHALL asynchronously force FSM=CLEAR, cnt=0, all pending bits=0, Ready=0; the array is not cleared by Rst itself.
REQ-021 After Rst deasserts, the sweep SHALL start on the first rising edge; Ready rises on the DEPTH-th edge.
REQ-022 Rst asserted mid-sweep or mid-operation SHALL restart from REQ-020; Rst dominates Clr.

Verification
REQ-023 Defaults, Rst pulse, then count edges -> Ready=0 for 31 edges, Ready=1 after edge 32; all 32 entries read 0.
REQ-024 IDLE, We=1 WA=5 WD=0xDEADBEEF, RA0=5 same cycle -> RD0=0xDEADBEEF combinationally; next cycle with We=0 -> RD0=0xDEADBEEF.
REQ-025 Iss IA=7; next cycle RA1=7 -> RBusy1=1; then We WA=7 WD=0x12 -> RBusy1=0 and RD1=0x12 in that cycle; pending[7]=0 afterwards.
REQ-026 Iss IA=3 and We WA=3 on the same edge -> RBusy=1 for RA=3 next cycle; We WA=0 WD=0xFFFF then RA0=0 -> RD0=0, RBusy0=0.
REQ-027 Write 0xA5 to entry 9, assert Clr for one edge, Rst mid-sweep at edge 10 -> Ready stays 0, sweep restarts, Ready=1 32 edges after Rst release, entry 9 reads 0.
REQ-028 NR=3, DW=16, AW=3 -> Ready after 8 edges; three ports reading entries 1, 1, 2 return independent correct data.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-entry scoreboard (pending) bits.
// Writes from the write-back port clear an entry's pending bit; an issue
// marks its destination pending. Reads are combinational with write-back
// bypass. A clear sweep zeroes the array one entry per clock after reset
// or after a Clr request; Ready is low for the duration of the sweep.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  output logic             Ready,
  input  logic [NR*AW-1:0] RA,
  output logic [NR*DW-1:0] RD,
  output logic [NR-1:0]    RBusy,
  input  logic             We,
  input  logic [AW-1:0]    WA,
  input  logic [DW-1:0]    WD,
  input  logic             Iss,
  input  logic [AW-1:0]    IA
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [DEPTH-1:0] pending;
  logic [DW-1:0]    mem [DEPTH];

  // Entry 0 is hardwired when ZERO_REG is set: it is never written or marked pending.
  logic wa_is_zero_reg;
  logic ia_is_zero_reg;
  logic sweep_en;
  logic wr_en;
  logic iss_en;

  assign wa_is_zero_reg = (ZERO_REG != 0) && (WA == '0);
  assign ia_is_zero_reg = (ZERO_REG != 0) && (IA == '0);

  // A Clr edge only restarts the sweep; it never writes an entry.
  assign sweep_en = (state == S_CLEAR) && !Clr;
  assign wr_en    = (state == S_IDLE) && !Clr && We && !wa_is_zero_reg;
  assign iss_en   = (state == S_IDLE) && !Clr && Iss && !ia_is_zero_reg;

  // Control FSM: sweep counter, pending bits and the registered Ready flag.
  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; blocking = would let later statements see new values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_CLEAR;
      cnt     <= '0;
      pending <= '0;
      Ready   <= 1'b0;
    end else if (Clr) begin
      state   <= S_CLEAR;
      cnt     <= '0;
      pending <= '0;
      Ready   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_IDLE;
            Ready <= 1'b1;
          end
        end
        S_IDLE: begin
          // Issue is applied after write-back so a same-address issue wins.
          if (We)     pending[WA] <= 1'b0;
          if (iss_en) pending[IA] <= 1'b1;
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
          Ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroed by the sweep, otherwise written by write-back.
  // NOTE: the array has no reset on purpose; the post-reset sweep is what
  // initialises it, which keeps it mappable onto RAM.
  always_ff @(posedge Clk) begin
    if (sweep_en) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[WA] <= WD;
    end
  end

  // Combinational read ports with write-back bypass and busy lookup.
  // NOTE: every output and temporary gets a default before the loop so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    logic [AW-1:0] ra_k;
    logic          hit;
    RD    = '0;
    RBusy = '0;
    ra_k  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NR; k++) begin
      ra_k = RA[k*AW +: AW];
      hit  = We && (WA == ra_k);
      if ((state == S_IDLE) && !((ZERO_REG != 0) && (ra_k == '0))) begin
        RD[k*DW +: DW] = hit ? WD : mem[ra_k];
        RBusy[k]       = pending[ra_k] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Directed vector table
// for bypass/scoreboard corners, hand sequences for sweep/Clr/Rst timing,
// and randomized traffic against a behavioural model of the register file.
module tb_regfile_sb;

  // Default-parameter instance signals
  logic        Clk = 1'b0;
  logic        Rst, Clr, We, Iss;
  logic [4:0]  WA, IA;
  logic [31:0] WD;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  RBusy;
  logic        Ready;

  // Small instance (NR=3, DW=16, AW=3) signals
  logic        Rst_s, Clr_s, We_s, Iss_s;
  logic [2:0]  WA_s, IA_s;
  logic [15:0] WD_s;
  logic [8:0]  RA_s;
  logic [47:0] RD_s;
  logic [2:0]  RBusy_s;
  logic        Ready_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  regfile_sb dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Ready(Ready), .RA(RA), .RD(RD),
    .RBusy(RBusy), .We(We), .WA(WA), .WD(WD), .Iss(Iss), .IA(IA)
  );

  regfile_sb #(.DW(16), .AW(3), .NR(3), .ZERO_REG(1)) dut_s (
    .Clk(Clk), .Rst(Rst_s), .Clr(Clr_s), .Ready(Ready_s), .RA(RA_s), .RD(RD_s),
    .RBusy(RBusy_s), .We(We_s), .WA(WA_s), .WD(WD_s), .Iss(Iss_s), .IA(IA_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 32-entry file ----------------
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_ready;
  int          m_left;   // sweep edges still to go before the file is usable

  function automatic void model_reset();
    m_ready = 1'b0;
    m_left  = 32;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endfunction

  function automatic void model_edge();
    if (Clr) begin
      model_reset();
    end else if (!m_ready) begin
      m_mem[32 - m_left] = '0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      if (We && WA != 0) m_mem[WA] = WD;
      if (We) m_pend[WA] = 1'b0;
      if (Iss && IA != 0) m_pend[IA] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready || a == 0) return '0;
    if (We && WA == a) return WD;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!m_ready || a == 0) return 1'b0;
    return m_pend[a] && !(We && WA == a);
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_ready"}, Ready, m_ready);
    check({tag, "_rd0"}, RD[31:0], exp_rd(RA[4:0]));
    check({tag, "_rd1"}, RD[63:32], exp_rd(RA[9:5]));
    check({tag, "_busy0"}, RBusy[0], exp_busy(RA[4:0]));
    check({tag, "_busy1"}, RBusy[1], exp_busy(RA[9:5]));
  endtask

  // One active edge with model update; returns 1 time unit after the edge.
  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    Clr = 1'b0; We = 1'b0; Iss = 1'b0;
    WA = '0; IA = '0; WD = '0; RA = '0;
  endtask

  // Counts edges until Ready rises, bounded; inputs stay idle meanwhile.
  task automatic count_to_ready(input string name, input int exp_edges);
    int n = 0;
    while (!Ready && n < 100) begin
      cycle();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    logic        b0, b1;
  } vec_t;

  vec_t tbl [12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12, 32'h12, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12, 32'h12, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd5, 32'h33, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h33, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3, 32'h0, 32'h33, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h33, 32'h0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 5'd3, 5'd5, 32'h44, 32'hDEADBEEF, 1'b0, 1'b0};

    foreach (m_mem[i]) m_mem[i] = '0;
    model_reset();

    // Reset state of both instances
    Rst = 1'b1; Rst_s = 1'b1;
    set_idle();
    Clr_s = 1'b0; We_s = 1'b0; Iss_s = 1'b0;
    WA_s = '0; IA_s = '0; WD_s = '0; RA_s = '0;
    #2;
    check("rst_ready", Ready, 1'b0);
    check("rst_busy", RBusy, 2'b00);
    check("rst_rd", RD, 64'h0);
    check("rst_ready_small", Ready_s, 1'b0);
    #4;
    Rst = 1'b0;
    model_reset();

    // Sweep length after reset release, then every entry reads zero
    count_to_ready("sweep_edges_after_rst", 32);
    for (int a = 0; a < 32; a += 2) begin
      RA = {5'(a + 1), 5'(a)};
      #2;
      check($sformatf("swept_rd0_e%0d", a), RD[31:0], 32'h0);
      check($sformatf("swept_rd1_e%0d", a + 1), RD[63:32], 32'h0);
      cycle();
    end

    // Directed bypass / scoreboard vectors
    foreach (tbl[i]) begin
      We = tbl[i].we; WA = tbl[i].wa; WD = tbl[i].wd;
      Iss = tbl[i].iss; IA = tbl[i].ia;
      RA = {tbl[i].ra1, tbl[i].ra0};
      #2;
      check($sformatf("vec%0d_rd0", i), RD[31:0], tbl[i].rd0);
      check($sformatf("vec%0d_rd1", i), RD[63:32], tbl[i].rd1);
      check($sformatf("vec%0d_busy0", i), RBusy[0], tbl[i].b0);
      check($sformatf("vec%0d_busy1", i), RBusy[1], tbl[i].b1);
      cycle();
    end
    set_idle();

    // Write entry 9, Clr for one edge, Rst partway through the sweep
    We = 1'b1; WA = 5'd9; WD = 32'hA5;
    #2;
    cycle();
    set_idle();
    RA = {5'd9, 5'd9};
    #2;
    check("e9_written", RD[31:0], 32'hA5);
    Clr = 1'b1;
    We = 1'b1; WA = 5'd4; WD = 32'h77;   // ignored: Clr edge writes nothing
    #2;
    cycle();
    set_idle();
    RA = {5'd9, 5'd9};
    check("clr_ready_low", Ready, 1'b0);
    for (int e = 1; e <= 9; e++) cycle();
    check("midsweep_ready", Ready, 1'b0);
    check("midsweep_rd", RD, 64'h0);
    Rst = 1'b1;
    #1;
    check("midsweep_rst_ready", Ready, 1'b0);
    Rst = 1'b0;
    model_reset();
    count_to_ready("sweep_edges_after_midsweep_rst", 32);
    #1;
    check("e9_cleared_p0", RD[31:0], 32'h0);
    check("e9_cleared_p1", RD[63:32], 32'h0);

    // Clr while sweep is running restarts the count
    Clr = 1'b1;
    #2;
    cycle();
    Clr = 1'b0;
    for (int e = 1; e <= 5; e++) cycle();
    Clr = 1'b1;
    #2;
    cycle();
    Clr = 1'b0;
    count_to_ready("sweep_edges_after_clr_restart", 32);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        Rst = 1'b1;
        set_idle();
        #1;
        check("rnd_rst_ready", Ready, 1'b0);
        Rst = 1'b0;
        model_reset();
      end
      Clr = ($urandom_range(0, 63) == 0);
      We  = 1'($urandom_range(0, 1));
      Iss = 1'($urandom_range(0, 1));
      WD  = $urandom;
      WA  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      IA  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      RA[4:0] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      RA[9:5] = ($urandom_range(0, 3) == 0) ? RA[4:0] : 5'($urandom_range(0, 7));
      #2;
      check_ports($sformatf("rnd%0d", i));
      cycle();
    end
    set_idle();

    // Small instance: 8-entry sweep and three independent read ports
    Rst_s = 1'b0;
    begin
      int n = 0;
      while (!Ready_s && n < 50) begin
        @(posedge Clk);
        #1;
        n++;
      end
      check("small_sweep_edges", n, 8);
    end
    RA_s = {3'd2, 3'd1, 3'd1};
    We_s = 1'b1; WA_s = 3'd1; WD_s = 16'h1111;
    #2;
    check("small_byp_p0", RD_s[15:0], 16'h1111);
    check("small_byp_p1", RD_s[31:16], 16'h1111);
    check("small_byp_p2", RD_s[47:32], 16'h0);
    @(posedge Clk); #1;
    WA_s = 3'd2; WD_s = 16'h2222;
    Iss_s = 1'b1; IA_s = 3'd1;
    #2;
    check("small_w2_p0", RD_s[15:0], 16'h1111);
    check("small_w2_p2", RD_s[47:32], 16'h2222);
    check("small_w2_busy", RBusy_s, 3'b000);
    @(posedge Clk); #1;
    We_s = 1'b0; Iss_s = 1'b0;
    #2;
    check("small_rd_p0", RD_s[15:0], 16'h1111);
    check("small_rd_p1", RD_s[31:16], 16'h1111);
    check("small_rd_p2", RD_s[47:32], 16'h2222);
    check("small_busy", RBusy_s, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
